wb_la_initiator: RTL

WB_LA_INITIATOR -- requirements
Module: wb_la_initiator

---
 rtl/wb_la_initiator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_la_initiator.sv
// Single-transfer Wishbone classic initiator: takes one host command, runs one
// bus cycle with an ack timeout, and returns read data or an error.
module wb_la_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Counter value on the last cycle the bus is allowed to wait for ack.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [31:0] adr_reg, adr_next;
  logic [31:0] dat_reg, dat_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] rsp_dat_reg, rsp_dat_next;
  logic        rsp_err_reg, rsp_err_next;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cyc_reg     <= 1'b0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      sel_reg     <= '0;
      rsp_dat_reg <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cyc_reg     <= cyc_next;
      we_reg      <= we_next;
      adr_reg     <= adr_next;
      dat_reg     <= dat_next;
      sel_reg     <= sel_next;
      rsp_dat_reg <= rsp_dat_next;
      rsp_err_reg <= rsp_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cyc_next     = cyc_reg;
    we_next      = we_reg;
    adr_next     = adr_reg;
    dat_next     = dat_reg;
    sel_next     = sel_reg;
    rsp_dat_next = rsp_dat_reg;
    rsp_err_next = rsp_err_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          adr_next   = cmd_adr;
          dat_next   = cmd_dat;
          sel_next   = cmd_sel;
          we_next    = cmd_we;
          cyc_next   = 1'b1;
          cnt_next   = '0;
          state_next = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (wbm_ack_i) begin
          cyc_next     = 1'b0;
          we_next      = 1'b0;
          rsp_dat_next = we_reg ? 32'h0 : wbm_dat_i;
          rsp_err_next = 1'b0;
          state_next   = RESP;
        end else if (cnt_reg == TO_LAST) begin
          cyc_next     = 1'b0;
          we_next      = 1'b0;
          rsp_dat_next = 32'h0;
          rsp_err_next = 1'b1;
          state_next   = RESP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_dat   = rsp_dat_reg;
  assign rsp_err   = rsp_err_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_sel_o = sel_reg;

endmodule
